wptr_full_level: RTL
====================

# wptr_full_level

Write-side pointer and full-flag generator for the dual-clock gray-pointer FIFO. It is the write-domain counterpart of the read-pointer/empty logic. It keeps the binary write address for the RAM and the gray write pointer that is sent to the read domain, and it raises `wfull` from the read pointer after two-flop synchronization. It also adds a registered fill level, an almost-full flag and a sticky overflow flag for the write-side controller.

## Interface
Parameters:
- `ADDRSIZE`, default 8: RAM address width. FIFO depth is 2^ADDRSIZE. Minimum value is 2.
- `AFULL_THRESH`, default 2^ADDRSIZE-4: fill level at or above which `walmost_full` asserts. Legal range is 1..2^ADDRSIZE.

Ports:
- `wclk`, input, 1: write clock. This is the only clock.
- `wrst_n`, input, 1: asynchronous active-low reset.
- `winc`, input, 1: write request for this cycle.
- `wq2_rptr`, input, ADDRSIZE+1: gray read pointer, already synchronized into `wclk`.
- `wovf_clr`, input, 1: clears `woverflow`.
- `wfull`, output, 1: FIFO full. Registered.
- `waddr`, output, ADDRSIZE: RAM write address, equal to `wbin[ADDRSIZE-1:0]`.
- `wptr`, output, ADDRSIZE+1: gray write pointer to the read-domain synchronizer. Registered.
- `wlevel`, output, ADDRSIZE+1: entries held, as seen from the write side. Range 0..2^ADDRSIZE. Registered.
- `walmost_full`, output, 1: asserted when `wlevel >= AFULL_THRESH`. Registered.
- `woverflow`, output, 1: sticky flag for a write attempted while full.

## Operation
- Internal state is `wbin` (ADDRSIZE+1 bits), a binary count modulo 2^(ADDRSIZE+1).
- Next-state logic:
  - `wbinnext = wbin + (winc & ~wfull)`. A write while full is dropped and the pointer does not move.
  - `wgraynext = (wbinnext>>1) ^ wbinnext`.
  - `{wbin, wptr} <= {wbinnext, wgraynext}` every cycle.
- Full detection:
  - `wfull_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]})`.
  - `wfull <= wfull_val`.
- Level:
  - `rbin_s = gray2bin(wq2_rptr)`.
  - `wlevel_next = (wbinnext - rbin_s) mod 2^(ADDRSIZE+1)`. The result is always ≤ 2^ADDRSIZE for legal input.
  - `wlevel <= wlevel_next`.
  - `walmost_full <= (wlevel_next >= AFULL_THRESH)`.
- Overflow:
  - `woverflow <= (winc & wfull) | (woverflow & ~wovf_clr)`.
  - When set and clear occur in the same cycle, set wins.
- The level is pessimistic: reads become visible only after synchronizer latency. It is never optimistic, so `wlevel` never under-reports the number of entries held.
- Every output except `waddr` is a flop. `waddr` is a direct slice of flop `wbin`.

## Timing
- Reset (`wrst_n` low, asynchronous): `wbin`, `wptr`, `waddr`, `wlevel` = 0; `wfull`, `walmost_full`, `woverflow` = 0.
- Reset mid-operation discards all state immediately. The read domain must be reset together with this block.
- A write accepted at edge N produces:
  - `waddr`, `wptr` and `wlevel` advance at edge N.
  - `wfull` reflects the new pointer at edge N. The write that fills the last entry sees `wfull=1` in the following cycle, with no extra bubble.
- A `wq2_rptr` change before edge N updates `wfull`, `wlevel` and `walmost_full` at edge N. This is one `wclk` of latency on top of the external synchronizer.
- Write and read-pointer advance in the same cycle: the level is unchanged, and `wfull` is recomputed from both new values.
- Wrap-around:
  - `waddr` wraps from 2^ADDRSIZE-1 to 0.
  - `wbin` wraps at 2^(ADDRSIZE+1).
  - `wptr` changes exactly one bit per accepted write, including across both wraps.

## Configuration
- Macro: `WPTR_FULL_LEVEL_EN`.
- Defined: the `gray2bin` conversion, the level subtractor and the almost-full comparator are built as described above.
- Undefined:
  - `wlevel` is tied to 0 and `walmost_full` is tied to 0. No conversion logic is synthesized.
  - `wfull`, `wptr`, `waddr` and `woverflow` behave identically to the defined case.

## Structure
- The shared package `fifo_pkg` holds:
  - the functions `bin2gray` and `gray2bin`, parameterized by width;
  - the `FIFO_ADDRSIZE_DEFAULT` constant.
  The read-side logic uses the same package.
- One sub-module, `gray2bin_conv`: a combinational gray-to-binary converter (XOR prefix from the MSB). It is instantiated only under `WPTR_FULL_LEVEL_EN`.

## Test plan
All scenarios use `ADDRSIZE=4` (depth 16) and `AFULL_THRESH=12`.
1. Reset applied mid-write-burst → all outputs 0 asynchronously. With `wrst_n` high again and `winc=0`, the outputs stay 0.
2. `wq2_rptr=0`, `winc=1` for 16 cycles → `wfull=1` after the 16th edge. At that point `wptr=5'b11000`, `waddr=0` and `wlevel=16`. `walmost_full` rises after the 12th edge.
3. A 17th write while full → `wptr` and `waddr` are unchanged and `woverflow=1`. `wovf_clr=1` alone clears it on the next edge. `wovf_clr=1` together with a full write keeps `woverflow=1`.
4. From full, set `wq2_rptr=5'b00110` (gray of 4) → at the next edge `wfull=0`, `wlevel=12` and `walmost_full=1`. Then `wq2_rptr=gray(5)` → `walmost_full=0` and `wlevel=11`.
5. Write and read-pointer advance in the same cycle at level 8 → level stays 8 and `wfull` stays 0.
6. 100 writes with `wq2_rptr` trailing by 3 → check each of the following:
   - every `wptr` transition flips exactly one bit;
   - `waddr` wraps 15→0;
   - `wlevel` stays 3 across the 31→0 pointer wrap.
   
   Repeat with the macro undefined → `wlevel` and `walmost_full` stay 0, and `wfull`/`wptr` are identical to the defined run.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock gray-pointer FIFO (write and read sides).
// Latency: n/a (constants and combinational functions only).
// Backpressure: n/a.
// Contents: FIFO_ADDRSIZE_DEFAULT, bin2gray(), gray2bin().
package fifo_pkg;

    localparam int FIFO_ADDRSIZE_DEFAULT = 8;

    // Both helpers work on a 32-bit carrier and so serve any pointer width up to
    // 32: callers zero-extend on the way in and truncate on the way out. Leading
    // zeros do not change a gray<->binary conversion.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_level_if.sv
// Bundle of write-side FIFO control signals between the write controller and wptr_full_level.
// Latency: n/a (wires only).
// Backpressure: wfull tells the master that further winc pulses are dropped.
// Modports: master drives winc/wq2_rptr/wovf_clr; slave (wptr_full_level) drives the status outputs.
interface wptr_full_level_if
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = FIFO_ADDRSIZE_DEFAULT
) ();
    logic                winc;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic                wovf_clr;
    logic                wfull;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   wlevel;
    logic                walmost_full;
    logic                woverflow;

    modport master (
        output winc, wq2_rptr, wovf_clr,
        input  wfull, waddr, wptr, wlevel, walmost_full, woverflow
    );

    modport slave (
        input  winc, wq2_rptr, wovf_clr,
        output wfull, waddr, wptr, wlevel, walmost_full, woverflow
    );

endinterface

// File: rtl/gray2bin_conv.sv
// Combinational gray-to-binary converter (XOR prefix from the MSB).
// Latency: 0 cycles.
// Backpressure: none.
// Ports: gray_i (W bits, gray code) -> bin_o (W bits, binary).
module gray2bin_conv #(
    parameter int W = 9
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);
    // bin[i] = XOR of gray[W-1:i], built as the XOR of all right shifts.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < W; i++) begin
            bin_o = bin_o ^ (gray_i >> i);
        end
    end

endmodule

// File: rtl/wptr_full_level.sv
// Write pointer, gray pointer and full flag for the dual-clock FIFO, plus fill level/almost-full/overflow.
// Latency: every output updates at the edge that accepts the write or samples wq2_rptr.
// Backpressure: writes while wfull are dropped and latched into the sticky woverflow.
// Ports: wclk, wrst_n (async active-low); interface w (slave): winc, wq2_rptr, wovf_clr in;
//        wfull, waddr, wptr, wlevel, walmost_full, woverflow out.
// Macro WPTR_FULL_LEVEL_EN: builds the level and almost-full path; otherwise both are tied to 0.
module wptr_full_level
    import fifo_pkg::*;
#(
    parameter int          ADDRSIZE     = FIFO_ADDRSIZE_DEFAULT,
    parameter int unsigned AFULL_THRESH = (1 << ADDRSIZE) - 4
) (
    input  logic             wclk,
    input  logic             wrst_n,
    wptr_full_level_if.slave w
);
    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_full;
    logic          wfull_q, wfull_d;
    logic          wovf_q, wovf_d;

    always_comb begin
        wbin_d    = wbin_q + PW'(w.winc & ~wfull_q);
        wptr_d    = PW'(bin2gray(32'(wbin_d)));
        // Full when the write pointer is exactly one lap ahead: in gray code that is
        // the read pointer with its top two bits inverted.
        rptr_full = {~w.wq2_rptr[ADDRSIZE -: 2], w.wq2_rptr[ADDRSIZE-2:0]};
        wfull_d   = (wptr_d == rptr_full);
        // A full write sets the flag even when a clear arrives in the same cycle.
        wovf_d    = (w.winc & wfull_q) | (wovf_q & ~w.wovf_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            wfull_q <= 1'b0;
            wovf_q  <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wptr_d;
            wfull_q <= wfull_d;
            wovf_q  <= wovf_d;
        end
    end

    assign w.wfull     = wfull_q;
    assign w.waddr     = wbin_q[ADDRSIZE-1:0];
    assign w.wptr      = wptr_q;
    assign w.woverflow = wovf_q;

`ifdef WPTR_FULL_LEVEL_EN
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0] rbin_s;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wafull_q, wafull_d;

    gray2bin_conv #(.W(PW)) u_rptr_conv (
        .gray_i (w.wq2_rptr),
        .bin_o  (rbin_s)
    );

    // Modular difference; the synchronized read pointer lags, so this never under-reports.
    assign wlevel_d = wbin_d - rbin_s;
    assign wafull_d = (wlevel_d >= AFULL_LVL);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel_q <= '0;
            wafull_q <= 1'b0;
        end else begin
            wlevel_q <= wlevel_d;
            wafull_q <= wafull_d;
        end
    end

    assign w.wlevel       = wlevel_q;
    assign w.walmost_full = wafull_q;
`else
    assign w.wlevel       = '0;
    assign w.walmost_full = 1'b0;
`endif

endmodule
